dm_hart_cmd_ctrl: RTL and testbench

//  Multi-hart abstract-command/resume sequencer for the debug module. It sits between the DM CSR block
//  (abstractcs/command/dmcontrol) and the debug memory, and steers go/resume to the selected hart.

---
 rtl/dm_hart_cmd_ctrl.sv | 146 ++++++++++++++
 tb/tb_dm_hart_cmd_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dm_hart_cmd_ctrl.sv
// Abstract-command / resume sequencer steering go and resume to the selected hart.
// Latency: go_o/resume_o/cmdbusy_o follow the registered state, one cycle after the triggering input.
// Backpressure: none; a command written while busy is dropped and flagged with cmderror=1.
module dm_hart_cmd_ctrl #(
  parameter int NR_HARTS  = 4,
  parameter int HARTSEL_W = 2,
  parameter int TIMEOUT_W = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [HARTSEL_W-1:0] hartsel_i,
  input  logic                 cmd_valid_i,
  input  logic                 unsupported_command_i,
  input  logic                 resumereq_i,
  input  logic                 haltreq_i,
  input  logic                 ndmreset_i,
  input  logic                 cmderror_clr_i,
  input  logic [NR_HARTS-1:0]  halted_i,
  input  logic [NR_HARTS-1:0]  halt_ack_i,
  input  logic [NR_HARTS-1:0]  going_i,
  input  logic [NR_HARTS-1:0]  resuming_i,
  input  logic [NR_HARTS-1:0]  exception_i,
  output logic [NR_HARTS-1:0]  go_o,
  output logic [NR_HARTS-1:0]  resume_o,
  output logic                 cmdbusy_o,
  output logic [2:0]           cmderror_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {IDLE, GO, EXEC, RESUME} state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_BUSY  = 3'd1;
  localparam logic [2:0] ERR_UNSUP = 3'd2;
  localparam logic [2:0] ERR_EXC   = 3'd3;
  localparam logic [2:0] ERR_HART  = 3'd4;
  localparam logic [2:0] ERR_TMO   = 3'd7;

  state_t               state_q, state_d;
  logic [HARTSEL_W-1:0] sel_q, sel_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic [2:0]           cmderror_q, cmderror_d, err_d;
  logic                 timeout_q, timeout_d;
  logic [NR_HARTS-1:0]  sel_oh;
  logic                 req_halted;
  logic                 going_sel, ack_sel, resuming_sel, exc_sel, tmo_hit;

  // One-hot of the latched hart, and halted status of the requested hart
  // (an out-of-range hartsel matches no bit, so it reads as not halted).
  always_comb begin
    sel_oh     = '0;
    req_halted = 1'b0;
    for (int i = 0; i < NR_HARTS; i++) begin
      if (sel_q == HARTSEL_W'(i))     sel_oh[i]  = 1'b1;
      if (hartsel_i == HARTSEL_W'(i)) req_halted = halted_i[i];
    end
  end

  assign going_sel    = |(going_i & sel_oh);
  assign ack_sel      = |(halt_ack_i & sel_oh);
  assign resuming_sel = |(resuming_i & sel_oh);
  assign exc_sel      = |(exception_i & sel_oh);
  assign wdog_inc     = wdog_q + TIMEOUT_W'(1);
  // Abort on the edge where the counter would reach all-ones: 2**TIMEOUT_W-1 cycles spent in the state.
  assign tmo_hit      = (wdog_inc == {TIMEOUT_W{1'b1}});

  // Next-state, error code and watchdog decode; progress events are checked before the watchdog.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    err_d     = ERR_NONE;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (unsupported_command_i) err_d = ERR_UNSUP;
          else if (!req_halted)      err_d = ERR_HART;
          else begin
            state_d = GO;
            sel_d   = hartsel_i;
          end
        end else if (resumereq_i && !haltreq_i && req_halted) begin
          state_d = RESUME;
          sel_d   = hartsel_i;
        end
      end
      GO: begin
        if (going_sel) state_d = EXEC;
        else if (tmo_hit) begin
          state_d = IDLE; err_d = ERR_TMO; timeout_d = 1'b1;
        end
      end
      EXEC: begin
        if (exc_sel) begin
          state_d = IDLE; err_d = ERR_EXC;
        end else if (ack_sel) state_d = IDLE;
        else if (tmo_hit) begin
          state_d = IDLE; err_d = ERR_TMO; timeout_d = 1'b1;
        end
      end
      RESUME: begin
        if (resuming_sel) state_d = IDLE;
        else if (tmo_hit) begin
          state_d = IDLE; err_d = ERR_TMO; timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A command written while busy is reported only if nothing higher ranked fired this cycle.
    if (state_q != IDLE && cmd_valid_i && err_d == ERR_NONE) err_d = ERR_BUSY;
    // ndmreset aborts whatever is running without touching cmderror or the latched hart.
    if (ndmreset_i) begin
      state_d   = IDLE;
      sel_d     = sel_q;
      err_d     = ERR_NONE;
      timeout_d = 1'b0;
    end
    wdog_d = (state_d == IDLE || state_d != state_q) ? '0 : wdog_inc;
    // First error is sticky; a clear in the same cycle as a new error leaves the new error.
    cmderror_d = (cmderror_clr_i || cmderror_q == ERR_NONE) ? err_d : cmderror_q;
  end

  // State, hart latch, watchdog and error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      wdog_q     <= '0;
      cmderror_q <= ERR_NONE;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wdog_q     <= wdog_d;
      cmderror_q <= cmderror_d;
      timeout_q  <= timeout_d;
    end
  end

  assign go_o       = (state_q == GO)     ? sel_oh : '0;
  assign resume_o   = (state_q == RESUME) ? sel_oh : '0;
  assign cmdbusy_o  = (state_q != IDLE);
  assign cmderror_o = cmderror_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_dm_hart_cmd_ctrl.sv
// Self-checking bench for dm_hart_cmd_ctrl (watchdog shortened to 4 bits).
// Latency: inputs applied 1ns after a rising edge, outputs checked 1ns after the next one.
// Backpressure: n/a.
module tb_dm_hart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] hartsel;
  logic       cmd_valid, unsup, resumereq, haltreq, ndmreset, clr;
  logic [3:0] halted, halt_ack, going, resuming, exception;
  logic [3:0] go, resume;
  logic       busy, tmo;
  logic [2:0] err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_hart_cmd_ctrl #(.NR_HARTS(4), .HARTSEL_W(2), .TIMEOUT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .hartsel_i(hartsel), .cmd_valid_i(cmd_valid),
    .unsupported_command_i(unsup), .resumereq_i(resumereq), .haltreq_i(haltreq),
    .ndmreset_i(ndmreset), .cmderror_clr_i(clr), .halted_i(halted),
    .halt_ack_i(halt_ack), .going_i(going), .resuming_i(resuming),
    .exception_i(exception), .go_o(go), .resume_o(resume), .cmdbusy_o(busy),
    .cmderror_o(err), .timeout_o(tmo)
  );

  typedef struct {
    logic [1:0] hs;
    logic       cv, un, rr, hr, cl;
    logic [3:0] hlt, ack, gng, rsm, exc;
    logic [3:0] e_go, e_res;
    logic       e_busy;
    logic [2:0] e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] hs, input logic cv, input logic un, input logic rr,
                     input logic hr, input logic cl, input logic [3:0] hlt, input logic [3:0] ack,
                     input logic [3:0] gng, input logic [3:0] rsm, input logic [3:0] exc,
                     input logic [3:0] e_go, input logic [3:0] e_res, input logic e_busy,
                     input logic [2:0] e_err);
    vec_t v;
    v.hs = hs; v.cv = cv; v.un = un; v.rr = rr; v.hr = hr; v.cl = cl;
    v.hlt = hlt; v.ack = ack; v.gng = gng; v.rsm = rsm; v.exc = exc;
    v.e_go = e_go; v.e_res = e_res; v.e_busy = e_busy; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    hartsel = 2'd0; cmd_valid = 1'b0; unsup = 1'b0; resumereq = 1'b0; haltreq = 1'b0;
    ndmreset = 1'b0; clr = 1'b0; halted = 4'h0; halt_ack = 4'h0; going = 4'h0;
    resuming = 4'h0; exception = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_go, input logic [3:0] e_res,
                            input logic e_busy, input logic [2:0] e_err, input logic e_tmo);
    check({tag, ".go"},     8'(go),     8'(e_go));
    check({tag, ".resume"}, 8'(resume), 8'(e_res));
    check({tag, ".busy"},   8'(busy),   8'(e_busy));
    check({tag, ".err"},    8'(err),    8'(e_err));
    check({tag, ".tmo"},    8'(tmo),    8'(e_tmo));
  endtask

  // Start a command on hart 0 (halted) and land in GO.
  task automatic start_cmd0();
    clear_inputs(); halted = 4'h1; cmd_valid = 1'b1;
    tick();
    clear_inputs(); halted = 4'h1;
  endtask

  initial begin
    //  hs     cv    un    rr    hr    clr   halted ack   going rsm   exc    e_go  e_res busy  err
    add(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0,  4'h4, 4'h0, 1'b1, 3'd0);
    add(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 4'h2, 4'h0, 4'h0,  4'h4, 4'h0, 1'b1, 3'd0);
    add(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0,  4'h0, 4'h0, 1'b1, 3'd0);
    add(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);
    add(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd4);
    add(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd4);
    add(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);
    add(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd2);
    add(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd4);
    add(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);
    add(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,  4'h1, 4'h0, 1'b1, 3'd0);
    add(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0,  4'h0, 4'h0, 1'b1, 3'd0);
    add(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b1, 3'd1);
    add(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2,  4'h0, 4'h0, 1'b1, 3'd1);
    add(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1,  4'h0, 4'h0, 1'b0, 3'd1);
    add(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);
    add(2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,  4'h2, 4'h0, 1'b1, 3'd0);
    add(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0,  4'h0, 4'h0, 1'b1, 3'd0);
    add(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);
    add(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h2, 1'b1, 3'd0);
    add(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0,  4'h0, 4'h2, 1'b1, 3'd0);
    add(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);
    add(2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);
    add(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);
    add(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h4, 1'b1, 3'd0);
    add(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h4, 1'b1, 3'd1);
    add(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0,  4'h0, 4'h0, 1'b0, 3'd0);

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 4'h0, 4'h0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    check_outs("idle", 4'h0, 4'h0, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      hartsel = vecs[i].hs; cmd_valid = vecs[i].cv; unsup = vecs[i].un;
      resumereq = vecs[i].rr; haltreq = vecs[i].hr; clr = vecs[i].cl;
      halted = vecs[i].hlt; halt_ack = vecs[i].ack; going = vecs[i].gng;
      resuming = vecs[i].rsm; exception = vecs[i].exc; ndmreset = 1'b0;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_go, vecs[i].e_res, vecs[i].e_busy,
                 vecs[i].e_err, 1'b0);
    end

    // Watchdog: GO held without going_i aborts on the 15th edge after entry.
    start_cmd0();
    check_outs("wd_enter", 4'h1, 4'h0, 1'b1, 3'd0, 1'b0);
    for (int k = 1; k < 15; k++) begin
      tick();
      if (tmo !== 1'b0 || busy !== 1'b1) begin
        checks++; errors++;
        $display("FAIL wd_early: tmo=%0b busy=%0b at cycle %0d, required tmo=0 busy=1", tmo, busy, k);
      end
    end
    tick();
    check_outs("wd_abort", 4'h0, 4'h0, 1'b0, 3'd7, 1'b1);
    tick();
    check_outs("wd_after", 4'h0, 4'h0, 1'b0, 3'd7, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("wd_clr.err", 8'(err), 8'd0);

    // Progress on the abort cycle wins over the watchdog.
    start_cmd0();
    repeat (14) tick();
    going = 4'h1;
    tick();
    going = 4'h0;
    check_outs("wd_progress", 4'h0, 4'h0, 1'b1, 3'd0, 1'b0);
    halt_ack = 4'h1;
    tick();
    halt_ack = 4'h0;
    check_outs("wd_done", 4'h0, 4'h0, 1'b0, 3'd0, 1'b0);

    // ndmreset in EXEC: back to IDLE, cmderror preserved.
    start_cmd0();
    going = 4'h1;
    tick();
    going = 4'h0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check_outs("ndm_busyerr", 4'h0, 4'h0, 1'b1, 3'd1, 1'b0);
    ndmreset = 1'b1;
    tick();
    ndmreset = 1'b0;
    check_outs("ndm_idle", 4'h0, 4'h0, 1'b0, 3'd1, 1'b0);

    // Asynchronous reset in RESUME clears everything before the next edge.
    clear_inputs(); hartsel = 2'd1; halted = 4'h2; resumereq = 1'b1;
    tick();
    check_outs("ar_resume", 4'h0, 4'h2, 1'b1, 3'd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_outs("ar_async", 4'h0, 4'h0, 1'b0, 3'd0, 1'b0);
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    check_outs("ar_release", 4'h0, 4'h0, 1'b0, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
